// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RISC-V controller.
// Optional branch extension: MC_CTRL_BRANCH_EXT_EN.
package multicycle_controller_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD,
    S_MEMWB, S_MEMWR, S_EXER, S_EXEI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR,
    S_LUI, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100,
    ALU_XOR = 3'b101
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_MEMDATA   = 2'b01,
    RES_ALURESULT = 2'b10,
    RES_IMMEXT    = 2'b11
  } result_src_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10
  } src_a_e;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } src_b_e;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_FUNC   = 2'b10
  } aluop_e;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decoder; flags func3 codes the controller cannot run.
// MC_CTRL_BRANCH_EXT_EN adds blt/bge compare support.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic [1:0] aluop,
  output logic [2:0] alu_ctrl,
  output logic       illegal_func
);

  logic unused_func7;
  assign unused_func7 = ^{func7[6], func7[4:0]};

  always_comb begin
    alu_ctrl     = ALU_ADD;
    illegal_func = 1'b0;
    unique case (aluop)
      ALUOP_BRANCH: begin
        unique case (func3)
          3'b000, 3'b001: alu_ctrl = ALU_SUB;
`ifdef MC_CTRL_BRANCH_EXT_EN
          3'b100, 3'b101: alu_ctrl = ALU_SLT;
`endif
          default: illegal_func = 1'b1;
        endcase
      end
      ALUOP_FUNC: begin
        unique case (func3)
          3'b000: begin
            if (op == OP_RTYPE && func7[5])
              alu_ctrl = ALU_SUB;
            else
              alu_ctrl = ALU_ADD;
          end
          3'b010: alu_ctrl = ALU_SLT;
          3'b100: alu_ctrl = ALU_XOR;
          3'b110: alu_ctrl = ALU_OR;
          3'b111: alu_ctrl = ALU_AND;
          default: illegal_func = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32 controller FSM with unified memory handshake.
// MC_CTRL_BRANCH_EXT_EN enables blt/bge in the decoder.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       instr_done,
  output logic       illegal
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   jalr_ph_q, jalr_ph_d;

  aluop_e     aluop;
  logic [2:0] dec_ctrl;
  logic       dec_ill;

  logic pc_w, ir_w, mem_w, reg_w, done;

  always_comb begin
    aluop = ALUOP_ADD;
    if (op == OP_RTYPE || op == OP_ITYPE)
      aluop = ALUOP_FUNC;
    else if (op == OP_BRANCH)
      aluop = ALUOP_BRANCH;
  end

  alu_decoder u_alu_dec (
    .op           (op),
    .func3        (func3),
    .func7        (func7),
    .aluop        (aluop),
    .alu_ctrl     (dec_ctrl),
    .illegal_func (dec_ill)
  );

  always_comb begin
    state_d    = state_q;
    jalr_ph_d  = 1'b0;
    pc_w       = 1'b0;
    ir_w       = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    done       = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ALUControl = ALU_ADD;
    ImmSrc     = IMM_I;
    unique case (state_q)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        if (mem_ready) begin
          ir_w    = 1'b1;
          pc_w    = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_B;
        unique case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:  state_d = dec_ill ? S_HALT : S_EXER;
          OP_ITYPE:  state_d = dec_ill ? S_HALT : S_EXEI;
          OP_BRANCH: state_d = dec_ill ? S_HALT : S_BRANCH;
          OP_JAL:    state_d = S_JAL;
          OP_JALR:   state_d = S_JALR;
          OP_LUI:    state_d = S_LUI;
          default:   state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        if (op == OP_STORE) begin
          ImmSrc  = IMM_S;
          state_d = S_MEMWR;
        end else begin
          state_d = S_MEMRD;
        end
      end
      S_MEMRD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_MEMDATA;
        reg_w     = 1'b1;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
        if (mem_ready) begin
          done    = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXER: begin
        ALUSrcA    = SRCA_RS1;
        ALUControl = dec_ctrl;
        state_d    = S_ALUWB;
      end
      S_EXEI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ALUControl = dec_ctrl;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w   = 1'b1;
        done    = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_RS1;
        ALUControl = dec_ctrl;
        // beq/bge take on zero; bne/blt take on !zero
        if (func3 == 3'b000 || func3 == 3'b101)
          pc_w = zero;
        else
          pc_w = ~zero;
        done    = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        pc_w    = 1'b1;
        reg_w   = 1'b1;
        done    = 1'b1;
        state_d = S_FETCH;
      end
      S_JALR: begin
        if (!jalr_ph_q) begin
          ALUSrcA   = SRCA_RS1;
          ALUSrcB   = SRCB_IMM;
          ResultSrc = RES_ALURESULT;
          pc_w      = 1'b1;
          jalr_ph_d = 1'b1;
        end else begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_FOUR;
          reg_w   = 1'b1;
          done    = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_LUI: begin
        ImmSrc    = IMM_U;
        ResultSrc = RES_IMMEXT;
        reg_w     = 1'b1;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT: ;
      default: state_d = S_HALT;
    endcase
    illegal_d = illegal_q | (state_d == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      jalr_ph_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      jalr_ph_q <= jalr_ph_d;
    end
  end

  assign PCWrite    = pc_w  & ~rst;
  assign IRWrite    = ir_w  & ~rst;
  assign MemWrite   = mem_w & ~rst;
  assign RegWrite   = reg_w & ~rst;
  assign instr_done = done  & ~rst;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: per-instruction cycle sequences from a
// behavioural model, checked by an independent monitor.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] func3 = 3'd0;
  logic [6:0] func7 = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;
  logic       instr_done, illegal;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .func3(func3),
    .func7(func7), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .MemWrite(MemWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .instr_done(instr_done),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

`ifdef MC_CTRL_BRANCH_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] RT = 7'b0110011, IT = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011, JL = 7'b1101111;
  localparam logic [6:0] JR = 7'b1100111, LU = 7'b0110111;

  localparam logic [1:0] R_OUT = 2'd0, R_MEM = 2'd1;
  localparam logic [1:0] R_ALU = 2'd2, R_IMM = 2'd3;
  localparam logic [1:0] A_PC = 2'd0, A_OLD = 2'd1, A_RS1 = 2'd2;
  localparam logic [1:0] B_RS2 = 2'd0, B_IMM = 2'd1, B_4 = 2'd2;
  localparam logic [2:0] X_ADD = 3'd0, X_SUB = 3'd1, X_AND = 3'd2;
  localparam logic [2:0] X_OR = 3'd3, X_SLT = 3'd4, X_XOR = 3'd5;
  localparam logic [2:0] I_I = 3'd0, I_S = 3'd1, I_B = 3'd2;
  localparam logic [2:0] I_U = 3'd4;

  typedef logic [18:0] vec_t;
  vec_t exp_q[$];
  vec_t act;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  assign act = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc,
                instr_done, illegal};

  // en = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite}
  function automatic vec_t mk(input logic [4:0] en,
                              input logic [1:0] rs, sa, sb,
                              input logic [2:0] alu, imm,
                              input logic dn, il);
    return {en, rs, sa, sb, alu, imm, dn, il};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // {legal, alu control} from the ISA rules
  function automatic logic [3:0] ref_alu(input logic [6:0] o,
                                         input logic [2:0] f3,
                                         input logic [6:0] f7);
    logic [3:0] r;
    r = 4'b0000;
    if (o == RT || o == IT) begin
      case (f3)
        3'd0: r = {1'b1, (o == RT && f7[5]) ? X_SUB : X_ADD};
        3'd2: r = {1'b1, X_SLT};
        3'd4: r = {1'b1, X_XOR};
        3'd6: r = {1'b1, X_OR};
        3'd7: r = {1'b1, X_AND};
        default: r = 4'b0000;
      endcase
    end else if (o == BR) begin
      if (f3 == 3'd0 || f3 == 3'd1) r = {1'b1, X_SUB};
      else if (EXT && (f3 == 3'd4 || f3 == 3'd5)) r = {1'b1, X_SLT};
    end
    return r;
  endfunction

  always @(negedge clk) begin
    vec_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL ctrl_vec cyc=%0d got=%b want=%b", cyc, act, e);
      end
    end
  end

  task automatic step(input logic r, input logic mr, input vec_t e);
    rst = r;
    mem_ready = mr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic halt_seq();
    for (int i = 0; i < 10; i++)
      step(1'b0, rbit(), mk(5'b0, R_OUT, A_PC, B_RS2, X_ADD, I_I, 1'b0, 1'b1));
    step(1'b1, rbit(), mk(5'b0, R_OUT, A_PC, B_RS2, X_ADD, I_I, 1'b0, 1'b1));
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3,
                           input logic [6:0] f7, input logic z,
                           input int wf, input int wm, input bit abort);
    logic [3:0] ra;
    logic       tk;
    op = o; func3 = f3; func7 = f7; zero = z;
    ra = ref_alu(o, f3, f7);
    for (int i = 0; i < wf; i++)
      step(1'b0, 1'b0, mk(5'b00000, R_ALU, A_PC, B_4, X_ADD, I_I, 1'b0, 1'b0));
    step(1'b0, 1'b1, mk(5'b10100, R_ALU, A_PC, B_4, X_ADD, I_I, 1'b0, 1'b0));
    step(1'b0, rbit(), mk(5'b0, R_OUT, A_OLD, B_IMM, X_ADD, I_B, 1'b0, 1'b0));
    case (o)
      LD: begin
        step(1'b0, rbit(), mk(5'b0, R_OUT, A_RS1, B_IMM, X_ADD, I_I, 1'b0, 1'b0));
        for (int i = 0; i < wm; i++)
          step(1'b0, 1'b0, mk(5'b01000, R_OUT, A_PC, B_RS2, X_ADD, I_I, 1'b0, 1'b0));
        step(1'b0, 1'b1, mk(5'b01000, R_OUT, A_PC, B_RS2, X_ADD, I_I, 1'b0, 1'b0));
        step(1'b0, rbit(), mk(5'b00001, R_MEM, A_PC, B_RS2, X_ADD, I_I, 1'b1, 1'b0));
      end
      ST: begin
        step(1'b0, rbit(), mk(5'b0, R_OUT, A_RS1, B_IMM, X_ADD, I_S, 1'b0, 1'b0));
        if (abort) begin
          step(1'b1, 1'b0, mk(5'b01000, R_OUT, A_PC, B_RS2, X_ADD, I_I, 1'b0, 1'b0));
        end else begin
          for (int i = 0; i < wm; i++)
            step(1'b0, 1'b0, mk(5'b01010, R_OUT, A_PC, B_RS2, X_ADD, I_I, 1'b0, 1'b0));
          step(1'b0, 1'b1, mk(5'b01010, R_OUT, A_PC, B_RS2, X_ADD, I_I, 1'b1, 1'b0));
        end
      end
      RT, IT: begin
        if (ra[3]) begin
          step(1'b0, rbit(), mk(5'b0, R_OUT, A_RS1, (o == RT) ? B_RS2 : B_IMM,
                                ra[2:0], I_I, 1'b0, 1'b0));
          step(1'b0, rbit(), mk(5'b00001, R_OUT, A_PC, B_RS2, X_ADD, I_I, 1'b1, 1'b0));
        end else begin
          halt_seq();
        end
      end
      BR: begin
        if (ra[3]) begin
          tk = (f3 == 3'd0 || f3 == 3'd5) ? z : ~z;
          step(1'b0, rbit(), mk({tk, 4'b0000}, R_OUT, A_RS1, B_RS2,
                                ra[2:0], I_I, 1'b1, 1'b0));
        end else begin
          halt_seq();
        end
      end
      JL: step(1'b0, rbit(), mk(5'b10001, R_OUT, A_OLD, B_4, X_ADD, I_I, 1'b1, 1'b0));
      JR: begin
        step(1'b0, rbit(), mk(5'b10000, R_ALU, A_RS1, B_IMM, X_ADD, I_I, 1'b0, 1'b0));
        step(1'b0, rbit(), mk(5'b00001, R_OUT, A_OLD, B_4, X_ADD, I_I, 1'b1, 1'b0));
      end
      LU: step(1'b0, rbit(), mk(5'b00001, R_IMM, A_PC, B_RS2, X_ADD, I_U, 1'b1, 1'b0));
      default: halt_seq();
    endcase
  endtask

  initial begin
    logic [6:0] ops [0:11];
    logic [6:0] o;
    ops = '{LD, ST, RT, IT, BR, JL, JR, LU, RT, IT,
            7'b0000000, 7'b0010111};
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // add x3,x1,x2
    run_instr(RT, 3'b000, 7'b0000000, 1'b0, 0, 0, 1'b0);
    run_instr(RT, 3'b000, 7'b0100000, 1'b1, 1, 0, 1'b0);
    run_instr(LD, 3'b010, 7'd0, 1'b0, 0, 3, 1'b0);
    run_instr(ST, 3'b010, 7'd0, 1'b0, 2, 2, 1'b0);
    run_instr(BR, 3'b000, 7'd0, 1'b1, 0, 0, 1'b0);
    run_instr(BR, 3'b000, 7'd0, 1'b0, 0, 0, 1'b0);
    run_instr(BR, 3'b001, 7'd0, 1'b0, 0, 0, 1'b0);
    run_instr(JL, 3'b000, 7'd0, 1'b0, 0, 0, 1'b0);
    run_instr(JR, 3'b000, 7'd0, 1'b0, 0, 0, 1'b0);
    run_instr(LU, 3'b000, 7'd0, 1'b0, 0, 0, 1'b0);
    run_instr(7'b0000000, 3'b000, 7'd0, 1'b0, 0, 0, 1'b0);
    run_instr(ST, 3'b010, 7'd0, 1'b0, 0, 3, 1'b1);
    run_instr(BR, 3'b100, 7'd0, 1'b0, 0, 0, 1'b0);
    run_instr(BR, 3'b101, 7'd0, 1'b1, 0, 0, 1'b0);
    run_instr(IT, 3'b001, 7'd0, 1'b0, 0, 0, 1'b0);
    for (int n = 0; n < 200; n++) begin
      o = ops[$urandom_range(0, 11)];
      run_instr(o, 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)),
                rbit(), $urandom_range(0, 2), $urandom_range(0, 3),
                ($urandom_range(0, 15) == 0));
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL: op  in  7  instr[6:0]; func3  in  3  instr[14:12]; func7  in  7  instr[31:25]; zero  in  1  ALU zero flag.
REQ-004 SHALL: mem_ready  in  1  unified memory access complete this cycle.
REQ-005 SHALL: PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite  out  1 each  datapath enables/selects.
REQ-006 SHALL: ResultSrc  out  2  00 ALUOut, 01 MemData, 10 ALUResult, 11 ImmExt.
REQ-007 SHALL: ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1.
REQ-008 SHALL: ALUSrcB  out  2  00 rs2, 01 ImmExt, 10 constant 4.
REQ-009 SHALL: ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 xor; ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
REQ-010 SHALL: instr_done  out  1  one-cycle pulse on final cycle of each instruction; illegal  out  1  sticky illegal-instruction flag.

Function
REQ-011 SHALL: Moore FSM, states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXER, EXEI, ALUWB, BRANCH, JAL, JALR, LUI, HALT.
REQ-012 SHALL: FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10; hold while mem_ready=0; when mem_ready=1 assert IRWrite=1, PCWrite=1 same cycle, go DECODE.
REQ-013 SHALL: DECODE (1 cycle): ALUSrcA=01, ALUSrcB=01, ImmSrc=B, add; dispatch on op: 0000011/0100011->MEMADR, 0110011->EXER, 0010011->EXEI, 1100011->BRANCH, 1101111->JAL, 1100111->JALR, 0110111->LUI, other->HALT with illegal=1.
REQ-014 SHALL: MEMADR: ALUSrcA=10, ALUSrcB=01, add, ImmSrc=I (load) or S (store); next MEMRD (load) or MEMWR (store).
REQ-015 SHALL: MEMRD: AdrSrc=1, ResultSrc=00; stay until mem_ready=1, then MEMWB. MEMWB: ResultSrc=01, RegWrite=1, instr_done=1, next FETCH.
REQ-016 SHALL: MEMWR: AdrSrc=1, ResultSrc=00, MemWrite=1 held until mem_ready=1; on that cycle instr_done=1, next FETCH.
REQ-017 SHALL: EXER: ALUSrcA=10, ALUSrcB=00; EXEI: ALUSrcA=10, ALUSrcB=01, ImmSrc=I; both next ALUWB. ALUWB: ResultSrc=00, RegWrite=1, instr_done=1, next FETCH.
REQ-018 SHALL: ALU decode: func3 000 -> add, except R-type with func7[5]=1 -> sub; 010 -> slt; 100 -> xor; 110 -> or; 111 -> and; other func3 in R/I -> HALT, illegal=1.
REQ-019 SHALL: BRANCH: ALUSrcA=10, ALUSrcB=00, ResultSrc=00; beq(000) sub, PCWrite=zero; bne(001) sub, PCWrite=!zero; instr_done=1; next FETCH.
REQ-020 SHALL: JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, RegWrite=1 (rd<=OldPC+4, PC<=branch target in ALUOut), instr_done=1.
REQ-021 SHALL: JALR: 2 cycles; cycle 1 ALUSrcA=10, ALUSrcB=01, ImmSrc=I, ResultSrc=10, PCWrite=1; cycle 2 as JAL writeback without PCWrite; instr_done on cycle 2.
REQ-022 SHALL: LUI: ImmSrc=U, ResultSrc=11, RegWrite=1, instr_done=1, next FETCH.
REQ-023 SHALL: HALT: all enables 0, illegal=1, remain until rst.
REQ-024 SHALL: unused select outputs drive 0 in every state; no enable asserted outside states listed above.

Reset
REQ-025 SHALL: on rst edge state<=FETCH, illegal<=0; PCWrite, IRWrite, MemWrite, RegWrite, instr_done forced 0 during any cycle rst=1, including mid-instruction and mid-wait.

Configuration
REQ-026 SHALL: macro MC_CTRL_BRANCH_EXT_EN defined -> BRANCH also accepts blt(100): ALUControl=slt, PCWrite=!zero; bge(101): slt, PCWrite=zero.
REQ-027 SHALL: MC_CTRL_BRANCH_EXT_EN undefined -> branch func3 other than 000/001 goes DECODE->HALT with illegal=1.

Structure
REQ-028 SHALL: shared package holds opcode constants, state encoding typedef, ALUControl/ImmSrc/ResultSrc/ALUSrc encodings.
REQ-029 SHALL: one combinational sub-module alu_decoder (op, func3, func7, aluop class -> ALUControl, illegal_func).

Verification
REQ-030 SHALL: add x3,x1,x2 (0x002081B3), mem_ready=1 -> FETCH,DECODE,EXER,ALUWB; RegWrite=1 only in 4th cycle; instr_done once.
REQ-031 SHALL: lw with mem_ready low 3 cycles in MEMRD -> state holds MEMRD 4 cycles, then MEMWB with ResultSrc=01, RegWrite=1.
REQ-032 SHALL: beq with zero=1 -> PCWrite=1 in BRANCH; zero=0 -> PCWrite=0; total 3 cycles.
REQ-033 SHALL: op=0000000 -> HALT, illegal=1 persists 10 cycles; rst -> FETCH, illegal=0.
REQ-034 SHALL: rst asserted during MEMWR wait -> MemWrite=0 that cycle, FETCH next.
REQ-035 SHALL: blt (func3=100) -> with MC_CTRL_BRANCH_EXT_EN ALUControl=100 in BRANCH; without, illegal=1.
